// File: rtl/seq_divider_if.sv
// Divide handshake bundle between the EX stage and the sequential divider.
// master = EX (initiator), slave = divider (responder).
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; zero only outside END.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BYZERO = 2'b01;
    localparam logic [1:0] ON     = 2'b10;
    localparam logic [1:0] END    = 2'b11;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   rem;
    logic               sgn_mode;
    logic               neg1;
    logic               neg2;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    logic               neg1_in;
    logic               neg2_in;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic               go;

    assign go = bus.start_i & ~bus.annul_i;

    always_comb begin
        neg1_in = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        neg2_in = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        mag1    = neg1_in ? -bus.opdata1_i : bus.opdata1_i;
        mag2    = neg2_in ? -bus.opdata2_i : bus.opdata2_i;
        // extra top bit of the shifted remainder doubles as the borrow
        rem_sh  = {rem, dvd[WIDTH-1]};
        diff    = rem_sh - {1'b0, dsr};
        ge      = ~diff[WIDTH];
        rem_nx  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx  = {dvd[WIDTH-2:0], ge};
        quo_fix = (sgn_mode & (neg1 ^ neg2)) ? -quo_nx : quo_nx;
        rem_fix = (sgn_mode & neg1) ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            sgn_mode <= 1'b0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            result   <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result <= '0;
                    ready  <= 1'b0;
                    if (go && bus.opdata2_i == '0) begin
                        state <= BYZERO;
                    end else if (go) begin
                        state    <= ON;
                        cnt      <= '0;
                        dvd      <= mag1;
                        dsr      <= mag2;
                        rem      <= '0;
                        sgn_mode <= bus.signed_div_i;
                        neg1     <= neg1_in;
                        neg2     <= neg2_in;
                    end
                end
                BYZERO: begin
                    state  <= END;
                    result <= '0;
                    ready  <= 1'b1;
                end
                ON: begin
                    if (!go) begin
                        state  <= FREE;
                        result <= '0;
                        ready  <= 1'b0;
                    end else begin
                        dvd <= quo_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state  <= END;
                            result <= {rem_fix, quo_fix};
                            ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // END: annul is ignored, only start release matters
                    if (!bus.start_i) begin
                        state  <= FREE;
                        result <= '0;
                        ready  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus abort/hold sequences.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_seq_divider;
    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rem;
        logic [31:0] quo;
        int          lat;
        int          hold;
    } vec_t;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    vec_t vecs[10];

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        bus.signed_div_i = v.sgn;
        bus.opdata1_i    = v.a;
        bus.opdata2_i    = v.b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        while (n < 100 && !got) begin
            tick();
            n++;
            if (bus.ready_o) got = 1'b1;
        end
        chk("latency", 64'(n), 64'(v.lat));
        chk("result", bus.result_o, {v.rem, v.quo});
        for (int h = 0; h < v.hold; h++) begin
            bus.opdata1_i = ~v.a;
            bus.opdata2_i = v.b + 32'd3;
            bus.annul_i   = 1'b1;
            tick();
            chk("hold_ready", 64'(bus.ready_o), 64'd1);
            chk("hold_result", bus.result_o, {v.rem, v.quo});
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        tick();
        chk("clear_ready", 64'(bus.ready_o), 64'd0);
        chk("clear_result", bus.result_o, 64'd0);
    endtask

    // mode 0: annul, 1: start dropped, 2: reset -- all at iteration 10
    task automatic abort_run(input int mode);
        bit seen;
        seen = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        tick();
        repeat (10) tick();
        if (mode == 0) bus.annul_i = 1'b1;
        if (mode == 1) bus.start_i = 1'b0;
        if (mode == 2) rst = 1'b1;
        tick();
        chk("abort_ready", 64'(bus.ready_o), 64'd0);
        chk("abort_result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        rst         = 1'b0;
        repeat (40) begin
            tick();
            if (bus.ready_o) seen = 1'b1;
        end
        chk("abort_no_ready", 64'(seen), 64'd0);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        vecs[0] = '{1'b0, 32'd100,       32'd7,
                    32'h2,        32'hE,        33, 5};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0};
        vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                    32'h0,        32'h80000000, 33, 0};
        vecs[3] = '{1'b1, 32'd7,        32'hFFFFFFFE,
                    32'h1,        32'hFFFFFFFD, 33, 0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h10,
                    32'hF,        32'h0FFFFFFF, 33, 0};
        vecs[5] = '{1'b0, 32'd5,        32'd0,
                    32'h0,        32'h0,        2,  3};
        vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                    32'hFFFFFFFE, 32'hE,        33, 0};
        vecs[7] = '{1'b0, 32'd3,        32'd5,
                    32'h3,        32'h0,        33, 0};
        vecs[8] = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                    32'h80000000, 32'h0,        33, 0};
        vecs[9] = '{1'b1, 32'hFFFFFFF9, 32'd0,
                    32'h0,        32'h0,        2,  0};

        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        tick();
        tick();
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        abort_run(0);
        abort_run(1);
        abort_run(2);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder side of the EX-stage divide handshake (start_i / ready_o / annul_i).
- EX holds start_i and the operands high while ready_o is low. It drops start_i in the cycle where ready_o is high, and in that cycle it captures result_o into the hi/lo write bus.
- result_o is {remainder, quotient}: hi takes the remainder and lo takes the quotient.

Parameters:
- WIDTH, 32, operand width. result_o is 2*WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock. Single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- signed_div_i  input  1  1 = signed (div), 0 = unsigned (divu). Sampled with start_i.
- opdata1_i  input  WIDTH  dividend. Sampled when start is accepted.
- opdata2_i  input  WIDTH  divisor. Sampled when start is accepted.
- start_i  input  1  request. Level-held by the initiator until it sees ready_o.
- annul_i  input  1  abort the current division.
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}. Registered.
- ready_o  output  1  result valid. Registered.

Behaviour:
- Reset: state = FREE, result_o = 0, ready_o = 0, counter = 0, internal operands = 0.
  - Reset has priority over every other event, including reset in the middle of a division.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0 and opdata2_i==0: go to BYZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0: latch operands, go to ON, counter = 0.
  - Otherwise stay in FREE with ready_o = 0 and result_o = 0.
- Operand latch (at start acceptance):
  - If signed_div_i=1, each negative operand is replaced by its two's-complement magnitude.
  - signed_div_i, the dividend sign and the divisor sign are stored for the final fixup.
- BYZERO: next edge goes to END with result_o = 0 and ready_o = 1.
- ON (each edge):
  - If annul_i=1 or start_i=0: go to FREE, clear result_o and ready_o.
  - Otherwise perform one iteration: shift {partial remainder, dividend} left by 1. If the partial remainder is >= the divisor magnitude, subtract the divisor and set the quotient LSB to 1.
  - counter increments each iteration.
  - On the iteration with counter == WIDTH-1: go to END, apply the sign fixup, register result_o, set ready_o = 1.
- Sign fixup (signed mode only):
  - The quotient is negated if the dividend and divisor signs differ.
  - The remainder is negated if the dividend was negative, so the remainder takes the dividend's sign.
  - Unsigned mode applies no fixup.
- END:
  - ready_o = 1 and result_o is held stable while start_i=1.
  - When start_i=0: go to FREE and clear ready_o and result_o on that edge.
  - annul_i in END is ignored (the result is already delivered).
- Latency: measured from the edge that accepts start in FREE.
  - Nonzero divisor: ready_o is high after WIDTH+1 edges (33 for WIDTH=32).
  - Zero divisor: ready_o is high after 2 edges.
- Back-to-back requests: a new start is accepted only from FREE. An END→FREE→ON sequence therefore costs at least one idle FREE cycle.
- Overflow: the signed case MIN / -1 gives quotient 0x80000000, remainder 0. This falls out of the unsigned core plus the fixup; no special case is needed.
- Operand changes on the input ports after start acceptance have no effect, because the latched copies are used.
- The result is never partially visible: result_o = 0 in all states except END.

Test Plan:
- Unsigned 100 / 7: signed_div_i=0, opdata1_i=100, opdata2_i=7, start_i held high → ready_o rises exactly 33 edges after acceptance, result_o = {32'h2, 32'hE}. Drop start_i in the same cycle → next cycle ready_o = 0, result_o = 0.
- Signed -7 / 2: signed_div_i=1, opdata1_i=32'hFFFFFFF9, opdata2_i=2 → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- Signed overflow and mixed signs:
  - 32'h80000000 / 32'hFFFFFFFF → result_o = {32'h0, 32'h80000000}.
  - 7 / -2 → result_o = {32'h1, 32'hFFFFFFFD}.
- Divide by zero: opdata2_i=0 → ready_o is high after 2 edges with result_o = 0. Keeping start_i high holds END; dropping it returns to FREE.
- Abort paths:
  - annul_i=1 at iteration 10 → FREE on the next edge and ready_o never asserts.
  - start_i dropped mid-ON → same response.
  - rst=1 mid-ON → all outputs 0 on the next edge, and a fresh 100 / 7 afterwards completes correctly in 33 edges.
- Handshake hold: keep start_i high for 5 cycles after ready_o rises → ready_o and result_o stay stable for all 5 cycles, and changing opdata1_i/opdata2_i in that window does not alter result_o.
